// File: rtl/cpu_trace_dumper_pkg.sv
// Shared definitions for the CPU trace dumper.
// Contents: the dump FSM state type, the fixed beat indices of a frame,
// the default header tag, and helpers that derive the frame geometry from
// the register and memory word counts.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HDR,
    ST_SEND_CTR,
    ST_SEND_REG,
    ST_SEND_MEM
  } dump_state_e;

  localparam logic [7:0] DEF_HDR_MAGIC = 8'hA5;

  // Beat layout: header, cycle, stall, flush, pc, then registers, then memory.
  localparam int IDX_HDR   = 0;
  localparam int IDX_CYC   = 1;
  localparam int IDX_STALL = 2;
  localparam int IDX_FLUSH = 3;
  localparam int IDX_PC    = 4;
  localparam int IDX_REG0  = 5;

  // First memory beat sits right after the last register beat.
  function automatic int idx_mem0(input int num_regs);
    return IDX_REG0 + num_regs;
  endfunction

  function automatic int frame_len(input int num_regs, input int mem_words);
    return IDX_REG0 + num_regs + mem_words;
  endfunction

endpackage

// File: rtl/cpu_trace_dumper_if.sv
// Dump stream port: one 32-bit beat per valid&&ready, last marks frame end.
//   valid  beat present (held until accepted)
//   ready  sink accepts the beat this edge
//   data   beat payload
//   last   final beat of a frame
interface cpu_trace_dumper_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/cpu_trace_dumper_sat_counter.sv
// Saturating up-counter.
//   clk_i    clock
//   rst_i    synchronous clear, active-low
//   en_i     count enable
//   count_o  current count, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (en_i && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (!rst_i) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cpu_trace_dumper.sv
// CPU trace dumper: counts cycles, stalls and flushes while the CPU runs and,
// on trigger_i, streams one frame: header, counters, PC, register file, then
// the first MEM_WORDS data-memory words.
//   clk_i, rst_i                   clock, synchronous active-low reset
//   start_i                        CPU running (counters advance only then)
//   stall_i, is_branch_i           hazard stall / branch-in-decode taps
//   br_equal_i                     branch comparator result
//   pc_i                           current PC, snapshotted with the counters
//   trigger_i                      dump request, level sampled every edge
//   reg_addr_o / reg_data_i        register-file debug read port
//   mem_addr_o / mem_data_i        data-memory debug read port (byte address)
//   dump                           frame stream (valid/ready/data/last)
//   busy_o                         frame in progress
//   trig_drop_o                    one-cycle pulse: trigger ignored while busy
module cpu_trace_dumper
  import cpu_dbg_pkg::*;
#(
  parameter int         CNT_W     = 32,
  parameter int         NUM_REGS  = 32,
  parameter int         MEM_WORDS = 8,
  parameter logic [7:0] HDR_MAGIC = DEF_HDR_MAGIC
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       stall_i,
  input  logic                       is_branch_i,
  input  logic                       br_equal_i,
  input  logic [31:0]                pc_i,
  input  logic                       trigger_i,
  output logic [4:0]                 reg_addr_o,
  input  logic [31:0]                reg_data_i,
  output logic [4:0]                 mem_addr_o,
  input  logic [31:0]                mem_data_i,
  cpu_trace_dumper_if.master         dump,
  output logic                       busy_o,
  output logic                       trig_drop_o
);

  localparam logic [15:0] LEN16    = 16'(frame_len(NUM_REGS, MEM_WORDS));
  localparam logic [15:0] LAST_IDX = 16'(frame_len(NUM_REGS, MEM_WORDS) - 1);
  localparam logic [15:0] REG0_IDX = 16'(IDX_REG0);
  localparam logic [15:0] MEM0_IDX = 16'(idx_mem0(NUM_REGS));

  logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(start_i), .count_o(cyc_cnt)
  );
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i),
    .en_i(start_i && stall_i && !is_branch_i), .count_o(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i),
    .en_i(start_i && br_equal_i && is_branch_i), .count_o(flush_cnt)
  );

  dump_state_e state_q, state_d;
  logic [15:0] idx_q, idx_d, idx_inc;
  logic [7:0]  seq_q, seq_d;
  logic        valid_q, valid_d, last_q, last_d, drop_q, drop_d;
  logic [31:0] snap_cyc_q, snap_cyc_d, snap_stall_q, snap_stall_d;
  logic [31:0] snap_flush_q, snap_flush_d, snap_pc_q, snap_pc_d;

  assign idx_inc = idx_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seq_d        = seq_q;
    valid_d      = valid_q;
    last_d       = last_q;
    drop_d       = 1'b0;
    snap_cyc_d   = snap_cyc_q;
    snap_stall_d = snap_stall_q;
    snap_flush_d = snap_flush_q;
    snap_pc_d    = snap_pc_q;
    if (state_q == ST_IDLE) begin
      if (trigger_i) begin
        state_d      = ST_SEND_HDR;
        idx_d        = 16'd0;
        valid_d      = 1'b1;
        last_d       = (LAST_IDX == 16'd0);
        snap_cyc_d   = 32'(cyc_cnt);
        snap_stall_d = 32'(stall_cnt);
        snap_flush_d = 32'(flush_cnt);
        snap_pc_d    = pc_i;
      end
    end else begin
      // Any trigger seen while a frame is active, including the edge that
      // accepts the last beat, is reported and otherwise ignored.
      drop_d = trigger_i;
      if (valid_q && dump.ready) begin
        if (last_q) begin
          state_d = ST_IDLE;
          idx_d   = 16'd0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          seq_d   = seq_q + 8'd1;
        end else begin
          idx_d  = idx_inc;
          last_d = (idx_inc == LAST_IDX);
          if (idx_inc < REG0_IDX)      state_d = ST_SEND_CTR;
          else if (idx_inc < MEM0_IDX) state_d = ST_SEND_REG;
          else                         state_d = ST_SEND_MEM;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      seq_q        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      drop_q       <= 1'b0;
      snap_cyc_q   <= '0;
      snap_stall_q <= '0;
      snap_flush_q <= '0;
      snap_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      seq_q        <= seq_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      drop_q       <= drop_d;
      snap_cyc_q   <= snap_cyc_d;
      snap_stall_q <= snap_stall_d;
      snap_flush_q <= snap_flush_d;
      snap_pc_q    <= snap_pc_d;
    end
  end

  // Payload is selected from registered state; register and memory words
  // come straight from the debug read ports addressed by the current beat.
  always_comb begin
    reg_addr_o = 5'd0;
    mem_addr_o = 5'd0;
    dump.data  = 32'd0;
    case (state_q)
      ST_SEND_HDR: dump.data = {HDR_MAGIC, seq_q, LEN16};
      ST_SEND_CTR: begin
        case (idx_q[2:0])
          3'(IDX_CYC):   dump.data = snap_cyc_q;
          3'(IDX_STALL): dump.data = snap_stall_q;
          3'(IDX_FLUSH): dump.data = snap_flush_q;
          default:       dump.data = snap_pc_q;
        endcase
      end
      ST_SEND_REG: begin
        reg_addr_o = 5'(idx_q - REG0_IDX);
        dump.data  = reg_data_i;
      end
      ST_SEND_MEM: begin
        mem_addr_o = {3'(idx_q - MEM0_IDX), 2'b00};
        dump.data  = mem_data_i;
      end
      default: dump.data = 32'd0;
    endcase
  end

  assign dump.valid  = valid_q;
  assign dump.last   = last_q;
  assign busy_o      = valid_q;
  assign trig_drop_o = drop_q;

endmodule

// File: tb/tb_cpu_trace_dumper.sv
// Self-checking bench for cpu_trace_dumper. Two instances run in lockstep:
// the default one (CNT_W=32) and a narrow one (CNT_W=4) whose counters must
// saturate at 15. Expected frames come from a counting model of the CPU taps.
module tb_cpu_trace_dumper;
  import cpu_dbg_pkg::*;

  localparam int LEN = 45;

  logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0;
  logic        stall_i = 1'b0, is_branch_i = 1'b0, br_equal_i = 1'b0, trigger_i = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic [4:0]  reg_addr, mem_addr, reg_addr_s, mem_addr_s;
  logic        busy, drop, busy_s, drop_s;
  logic [31:0] regs [32];
  logic [31:0] memw [8];

  cpu_trace_dumper_if dif ();
  cpu_trace_dumper_if dif_s ();

  cpu_trace_dumper dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .is_branch_i(is_branch_i), .br_equal_i(br_equal_i), .pc_i(pc_i),
    .trigger_i(trigger_i), .reg_addr_o(reg_addr), .reg_data_i(regs[reg_addr]),
    .mem_addr_o(mem_addr), .mem_data_i(memw[mem_addr[4:2]]), .dump(dif),
    .busy_o(busy), .trig_drop_o(drop)
  );

  cpu_trace_dumper #(.CNT_W(4)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .is_branch_i(is_branch_i), .br_equal_i(br_equal_i), .pc_i(pc_i),
    .trigger_i(trigger_i), .reg_addr_o(reg_addr_s), .reg_data_i(regs[reg_addr_s]),
    .mem_addr_o(mem_addr_s), .mem_data_i(memw[mem_addr_s[4:2]]), .dump(dif_s),
    .busy_o(busy_s), .trig_drop_o(drop_s)
  );

  always #5 clk_i = ~clk_i;

  // Reference event counts (unbounded); saturation is applied when compared.
  longint unsigned m_cyc = 0, m_stall = 0, m_flush = 0;
  int              m_seq = 0;
  longint unsigned s_cyc, s_stall, s_flush;
  logic [31:0]     s_pc;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      m_cyc <= 0; m_stall <= 0; m_flush <= 0;
    end else if (start_i) begin
      m_cyc <= m_cyc + 1;
      if (stall_i && !is_branch_i) m_stall <= m_stall + 1;
      if (br_equal_i && is_branch_i) m_flush <= m_flush + 1;
    end
  end

  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input longint unsigned v, input int w);
    longint unsigned lim;
    lim = (w >= 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
    return (v > lim) ? lim[31:0] : v[31:0];
  endfunction

  function automatic logic [31:0] exp_word(input int k, input int w);
    logic [7:0] sq;
    sq = 8'(m_seq);
    if (k == 0) return {8'hA5, sq, 16'(LEN)};
    if (k == 1) return sat(s_cyc, w);
    if (k == 2) return sat(s_stall, w);
    if (k == 3) return sat(s_flush, w);
    if (k == 4) return s_pc;
    if (k < 37) return regs[k-5];
    return memw[k-37];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, {31'd0, dif.valid}, 32'd0);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".last"}, {31'd0, dif.last}, 32'd0);
    check({tag, ".drop"}, {31'd0, drop}, 32'd0);
    check({tag, ".data"}, dif.data, 32'd0);
    check({tag, ".addr"}, {22'd0, reg_addr, mem_addr}, 32'd0);
    check({tag, ".s_valid"}, {31'd0, dif_s.valid}, 32'd0);
    check({tag, ".s_data"}, dif_s.data, 32'd0);
  endtask

  task automatic drive_rand();
    stall_i     = 1'($urandom % 2);
    is_branch_i = (($urandom % 4) == 0);
    br_equal_i  = 1'($urandom % 2);
    pc_i        = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic fire();
    @(negedge clk_i);
    trigger_i = 1'b1;
    s_cyc = m_cyc; s_stall = m_stall; s_flush = m_flush; s_pc = pc_i;
    @(posedge clk_i);
    #1 trigger_i = 1'b0;
  endtask

  // mode 0: ready held 1; 1: ready 0/1 alternating; 2: random ready.
  // drop_at: raise trigger while beat drop_at is pending. abort_at: reset there.
  task automatic run_frame(input string tag, input int mode, input int drop_at, input int abort_at);
    int   k = 0, cyc = 0, drop_ph = 0;
    bit   done = 0;
    logic r;
    while (!done && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      drive_rand();
      if (drop_ph == 1) begin
        check({tag, ".drop_pulse"}, {31'd0, drop}, 32'd1);
        check({tag, ".drop_pulse_s"}, {31'd0, drop_s}, 32'd1);
        trigger_i = 1'b0;
        drop_ph = 2;
      end else if (drop_ph == 2) begin
        check({tag, ".drop_single"}, {31'd0, drop}, 32'd0);
        drop_ph = 3;
      end
      if (abort_at >= 0 && k == abort_at) begin
        rst_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        check({tag, ".rst_valid"}, {31'd0, dif.valid}, 32'd0);
        check({tag, ".rst_valid_s"}, {31'd0, dif_s.valid}, 32'd0);
        @(negedge clk_i);
        check_idle({tag, ".rst"});
        rst_i = 1'b1;
        m_seq = 0;
        dif.ready = 1'b0;
        dif_s.ready = 1'b0;
        return;
      end
      if (drop_at >= 0 && k == drop_at && drop_ph == 0) begin
        trigger_i = 1'b1;
        drop_ph = 1;
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom % 2);
      dif.ready = r;
      dif_s.ready = r;
      check($sformatf("%s.valid[%0d]", tag, k), {31'd0, dif.valid}, 32'd1);
      check($sformatf("%s.busy[%0d]", tag, k), {31'd0, busy}, 32'd1);
      check($sformatf("%s.data[%0d]", tag, k), dif.data, exp_word(k, 32));
      check($sformatf("%s.last[%0d]", tag, k), {31'd0, dif.last}, {31'd0, k == LEN-1});
      check($sformatf("%s.s_data[%0d]", tag, k), dif_s.data, exp_word(k, 4));
      check($sformatf("%s.s_last[%0d]", tag, k), {31'd0, dif_s.last}, {31'd0, k == LEN-1});
      if (r) begin
        if (k == LEN-1) done = 1;
        k++;
      end
    end
    check({tag, ".frame_done"}, {31'd0, done}, 32'd1);
    if (mode == 0) check({tag, ".throughput"}, cyc, LEN);
    if (mode == 1) check({tag, ".within_90"}, {31'd0, cyc <= 90}, 32'd1);
    @(negedge clk_i);
    if (drop_ph == 1) begin
      check({tag, ".drop_at_last"}, {31'd0, drop}, 32'd1);
      trigger_i = 1'b0;
    end
    check({tag, ".end_valid"}, {31'd0, dif.valid}, 32'd0);
    check({tag, ".end_busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".end_valid_s"}, {31'd0, dif_s.valid}, 32'd0);
    dif.ready = 1'b0;
    dif_s.ready = 1'b0;
    m_seq = (m_seq + 1) % 256;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 8; i++) memw[i] = $urandom;
    regs[8] = 32'd7;
    memw[0] = 32'd5;
    dif.ready = 1'b0;
    dif_s.ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk_i);
    check_idle("reset");
    rst_i = 1'b1;

    // Directed counting: 10 running cycles, 3 counted stalls (a fourth is
    // masked by a branch), 2 taken-branch flushes.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      start_i     = 1'b1;
      stall_i     = (i <= 3);
      is_branch_i = (i == 3) || (i == 5) || (i == 6);
      br_equal_i  = (i == 4) || (i == 5) || (i == 6);
    end
    @(negedge clk_i);
    stall_i = 1'b0; is_branch_i = 1'b0; br_equal_i = 1'b0;
    fire();
    run_frame("count", 0, -1, -1);

    // Backpressure with alternating ready.
    repeat (5) begin @(negedge clk_i); drive_rand(); end
    fire();
    run_frame("bp", 1, -1, -1);

    // Trigger while busy at beat 10.
    fire();
    run_frame("drop10", 0, 10, -1);

    // Random ready; trigger on the edge that accepts the last beat.
    repeat (3) begin @(negedge clk_i); drive_rand(); end
    fire();
    run_frame("droplast", 2, LEN-1, -1);

    // Reset mid-frame at beat 20, then a fresh frame with idle counters.
    fire();
    run_frame("abort", 0, -1, 20);
    repeat (3) @(negedge clk_i);
    fire();
    run_frame("post_rst", 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
